// File: rtl/rib_arbiter.sv
// Three-master RIB bus arbiter: grants one master at a time, holds the slave
// request until ack or timeout, and returns registered rdata/ack/err pulses.
module rib_arbiter #(
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  input  logic        m2_req_i,
  input  logic        m2_we_i,
  input  logic [31:0] m2_addr_i,
  input  logic [31:0] m2_wdata_i,
  input  logic [3:0]  m2_sel_i,
  output logic [31:0] m2_rdata_o,
  output logic        m2_ack_o,
  output logic        m2_err_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        hold_flag_o
);

  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [7:0]  tcnt_q;
  logic [3:0]  starve_q;
  logic [2:0]  ack_q, err_q;
  logic [31:0] rdata_q [3];

  logic [1:0]  winner;
  logic        grant_ok;
  logic        time_up;
  logic        done;
  logic [2:0]  owner_oh;
  logic        win_we;
  logic [31:0] win_addr, win_wdata;
  logic [3:0]  win_sel;

  // A starved m2 overrides the fixed m0 > m1 > m2 order.
  always_comb begin
    winner = 2'd3;
    if (m2_req_i && (starve_q >= STARVE_LIM)) winner = 2'd2;
    else if (m0_req_i)                        winner = 2'd0;
    else if (m1_req_i)                        winner = 2'd1;
    else if (m2_req_i)                        winner = 2'd2;
  end

  always_comb begin
    win_we    = m0_we_i;
    win_addr  = m0_addr_i;
    win_wdata = m0_wdata_i;
    win_sel   = m0_sel_i;
    if (winner == 2'd1) begin
      win_we    = m1_we_i;
      win_addr  = m1_addr_i;
      win_wdata = m1_wdata_i;
      win_sel   = m1_sel_i;
    end else if (winner == 2'd2) begin
      win_we    = m2_we_i;
      win_addr  = m2_addr_i;
      win_wdata = m2_wdata_i;
      win_sel   = m2_sel_i;
    end
  end

  assign time_up  = (tcnt_q == TO_LAST);
  assign owner_oh = 3'b001 << grant_o;

  // The ack cycle is an enforced IDLE gap, so a master still holding req
  // while its ack is visible is not granted again.
  always_comb begin
    state_d  = state_q;
    grant_ok = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        grant_ok = (ack_q == 3'b000) && (winner != 2'd3);
        if (grant_ok) state_d = BUSY;
      end
      BUSY: begin
        done = s_ack_i || time_up;
        if (done) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      starve_q  <= '0;
      grant_o   <= 2'd3;
      s_req_o   <= 1'b0;
      s_we_o    <= 1'b0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      s_sel_o   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      err_q   <= '0;
      for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
      if (!m2_req_i) starve_q <= '0;

      if (grant_ok) begin
        s_req_o   <= 1'b1;
        s_we_o    <= win_we;
        s_addr_o  <= win_addr;
        s_wdata_o <= win_wdata;
        s_sel_o   <= win_sel;
        grant_o   <= winner;
        tcnt_q    <= '0;
        if (winner == 2'd2 || !m2_req_i) starve_q <= '0;
        else if (starve_q != 4'hf)       starve_q <= starve_q + 4'd1;
      end

      if (state_q == BUSY) begin
        if (done) begin
          ack_q   <= owner_oh;
          err_q   <= s_ack_i ? 3'b000 : owner_oh;
          s_req_o <= 1'b0;
          grant_o <= 2'd3;
          for (int i = 0; i < 3; i++)
            if (owner_oh[i] && s_ack_i) rdata_q[i] <= s_rdata_i;
        end else begin
          tcnt_q <= tcnt_q + 8'd1;
        end
      end
    end
  end

  assign m0_ack_o   = ack_q[0];
  assign m1_ack_o   = ack_q[1];
  assign m2_ack_o   = ack_q[2];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign m2_err_o   = err_q[2];
  assign m0_rdata_o = rdata_q[0];
  assign m1_rdata_o = rdata_q[1];
  assign m2_rdata_o = rdata_q[2];

  assign hold_flag_o = m1_req_i & ~m1_ack_o;

endmodule
